// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-file target.
// FSM encoding, R/W bit meaning and the default ADV7511 bus address.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        MACK
    } tgt_state_t;

    localparam logic       I2C_RW_WRITE      = 1'b0;
    localparam logic       I2C_RW_READ       = 1'b1;
    localparam logic [6:0] ADV7511_MAIN_ADDR = 7'h39;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus stability-counter glitch filter for one I2C line.
// The filtered level changes only after FILTER_LEN consecutive stable samples; rise/fall pulse with it.
module i2c_line_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic       level_q, level_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;
    logic [3:0] cnt_q, cnt_d;

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == 4'(FILTER_LEN - 1)) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments; idle bus lines reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target mapping pointer-based write and read transactions onto a register-file port.
// SDA is only ever pulled low for ACK bits and read data; no clock stretching.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = ADV7511_MAIN_ADDR,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_oen,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       addressed,
    output logic       nak_seen
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .pin_i   (scl_i),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .pin_i   (sda_i),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    tgt_state_t state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    logic       phase_q, phase_d;
    logic       sda_oen_q, sda_oen_d;
    logic       addressed_q, addressed_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       reg_we_q, reg_we_d;
    logic       reg_re_q, reg_re_d;
    logic       nak_seen_q, nak_seen_d;
    logic [7:0] rdata_sr_q, rdata_sr_d;
    logic [7:0] rx_byte;

    assign rx_byte = {shift_q, sda_lvl};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        phase_d     = phase_q;
        sda_oen_d   = sda_oen_q;
        addressed_d = addressed_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        nak_seen_d  = 1'b0;
        rdata_sr_d  = rdata_sr_q;

        // Register file answers one clk after the read strobe.
        if (reg_re_q) begin
            rdata_sr_d = reg_rdata;
        end

        if (start_det || stop_det) begin
            state_d     = start_det ? ADDR : IDLE;
            bit_cnt_d   = 3'd7;
            phase_d     = 1'b0;
            sda_oen_d   = 1'b1;
            addressed_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;

                ADDR, REG, WDATA: begin
                    if (scl_rise) begin
                        shift_d = rx_byte[6:0];
                        phase_d = 1'b0;
                        if (bit_cnt_q != 3'd0) begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end else if (state_q == ADDR) begin
                            // A foreign address drops straight back to IDLE without touching SDA.
                            if (rx_byte[7:1] == SLAVE_ADDR) begin
                                rw_d    = rx_byte[0];
                                state_d = ADDR_ACK;
                            end else begin
                                state_d = IDLE;
                            end
                        end else if (state_q == REG) begin
                            reg_addr_d = rx_byte;
                            state_d    = REG_ACK;
                        end else begin
                            reg_wdata_d = rx_byte;
                            reg_we_d    = 1'b1;
                            state_d     = WDATA_ACK;
                        end
                    end
                end

                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oen_d   = 1'b0;
                            addressed_d = 1'b1;
                            phase_d     = 1'b1;
                            reg_re_d    = (rw_q == I2C_RW_READ);
                        end else if (rw_q == I2C_RW_WRITE) begin
                            sda_oen_d = 1'b1;
                            phase_d   = 1'b0;
                            bit_cnt_d = 3'd7;
                            state_d   = REG;
                        end else begin
                            // First read bit goes out on the same fall that ends the ACK.
                            sda_oen_d  = rdata_sr_q[7];
                            rdata_sr_d = {rdata_sr_q[6:0], 1'b0};
                            phase_d    = 1'b0;
                            bit_cnt_d  = 3'd6;
                            state_d    = RDATA;
                        end
                    end
                end

                REG_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oen_d = 1'b0;
                            phase_d   = 1'b1;
                        end else begin
                            sda_oen_d = 1'b1;
                            phase_d   = 1'b0;
                            bit_cnt_d = 3'd7;
                            state_d   = WDATA;
                            if (state_q == WDATA_ACK) begin
                                reg_addr_d = reg_addr_q + 8'd1;
                            end
                        end
                    end
                end

                RDATA: begin
                    if (scl_fall) begin
                        sda_oen_d  = rdata_sr_q[7];
                        rdata_sr_d = {rdata_sr_q[6:0], 1'b0};
                        if (bit_cnt_q == 3'd0) begin
                            phase_d = 1'b0;
                            state_d = MACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end
                end

                MACK: begin
                    // phase_q marks that SDA has been released for the master's ACK bit.
                    if (scl_fall && !phase_q) begin
                        sda_oen_d = 1'b1;
                        phase_d   = 1'b1;
                    end else if (scl_rise && phase_q) begin
                        phase_d = 1'b0;
                        if (!sda_lvl) begin
                            reg_addr_d = reg_addr_q + 8'd1;
                            reg_re_d   = 1'b1;
                            bit_cnt_d  = 3'd7;
                            state_d    = RDATA;
                        end else begin
                            nak_seen_d = 1'b1;
                            state_d    = IDLE;
                        end
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd7;
            shift_q     <= '0;
            rw_q        <= I2C_RW_WRITE;
            phase_q     <= 1'b0;
            sda_oen_q   <= 1'b1;
            addressed_q <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            nak_seen_q  <= 1'b0;
            rdata_sr_q  <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            phase_q     <= phase_d;
            sda_oen_q   <= sda_oen_d;
            addressed_q <= addressed_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            nak_seen_q  <= nak_seen_d;
            rdata_sr_q  <= rdata_sr_d;
        end
    end

    assign sda_o     = 1'b0;
    assign sda_oen   = sda_oen_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;
    assign addressed = addressed_q;
    assign nak_seen  = nak_seen_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-level I2C master BFM drives the bus while a
// monitor logs register strobes; expected values are hand-derived constants.
module tb_i2c_target;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_line;
    logic       sda_o, sda_oen, reg_we, reg_re, addressed, nak_seen;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;

    assign sda_line  = m_sda & sda_oen;
    assign reg_rdata = (reg_addr == 8'h10) ? 8'h5A :
                       (reg_addr == 8'h11) ? 8'hC3 : 8'hEE;

    i2c_target #(.SLAVE_ADDR(7'h39), .FILTER_LEN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (m_scl),
        .sda_i     (sda_line),
        .sda_o     (sda_o),
        .sda_oen   (sda_oen),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .addressed (addressed),
        .nak_seen  (nak_seen)
    );

    always #10 clk = ~clk;

    // Strobe monitor.
    logic [7:0] we_addr_q[$];
    logic [7:0] we_data_q[$];
    logic [7:0] re_addr_q[$];
    int nak_cnt = 0;
    int low_cnt = 0;
    int adr_cnt = 0;

    always @(negedge clk) begin
        if (reg_we === 1'b1) begin
            we_addr_q.push_back(reg_addr);
            we_data_q.push_back(reg_wdata);
        end
        if (reg_re === 1'b1) re_addr_q.push_back(reg_addr);
        if (nak_seen === 1'b1) nak_cnt++;
        if (sda_oen === 1'b0) low_cnt++;
        if (addressed === 1'b1) adr_cnt++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_clks(Q);
        m_scl = 1'b1; wait_clks(Q);
        m_sda = 1'b0; wait_clks(Q);
        m_scl = 1'b0; wait_clks(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clks(Q);
        m_scl = 1'b1; wait_clks(Q);
        m_sda = 1'b1; wait_clks(Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda = b;    wait_clks(Q);
        m_scl = 1'b1; wait_clks(2 * Q);
        m_scl = 1'b0; wait_clks(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; wait_clks(Q);
        m_scl = 1'b1; wait_clks(Q);
        b = sda_line; wait_clks(Q);
        m_scl = 1'b0; wait_clks(Q);
    endtask

    // glitch_bit selects the bit whose SCL-high phase gets a 2-clk low pulse (-1 = none).
    task automatic write_byte(input logic [7:0] b, output logic ack, input int glitch_bit = -1);
        for (int i = 7; i >= 0; i--) begin
            if (i == glitch_bit) begin
                m_sda = b[i]; wait_clks(Q);
                m_scl = 1'b1; wait_clks(Q);
                m_scl = 1'b0; wait_clks(2);
                m_scl = 1'b1; wait_clks(Q - 2);
                m_scl = 1'b0; wait_clks(Q);
            end else begin
                write_bit(b[i]);
            end
        end
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] b, input logic nack);
        logic bt;
        for (int i = 7; i >= 0; i--) begin
            read_bit(bt);
            b[i] = bt;
        end
        write_bit(nack);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic       a0, a1, a2, a3, a4;
        logic [7:0] rb0, rb1;
        int         we0, re0, nak0, low0, adr0;
        logic       seen;

        // Reset state
        wait_clks(3);
        check("rst_sda_oen",   32'(sda_oen),   32'(1));
        check("rst_sda_o",     32'(sda_o),     32'(0));
        check("rst_reg_addr",  32'(reg_addr),  32'h00);
        check("rst_reg_wdata", 32'(reg_wdata), 32'h00);
        check("rst_reg_we",    32'(reg_we),    32'(0));
        check("rst_reg_re",    32'(reg_re),    32'(0));
        check("rst_addressed", 32'(addressed), 32'(0));
        check("rst_nak_seen",  32'(nak_seen),  32'(0));
        rst_n = 1'b1;
        wait_clks(10);

        // Single write: 0x39/W, reg 0x41, data 0x10
        we0 = we_addr_q.size();
        i2c_start();
        write_byte(8'h72, a0);
        check("t1_addr_ack", 32'(a0), 32'(0));
        check("t1_addressed_hi", 32'(addressed), 32'(1));
        write_byte(8'h41, a1);
        write_byte(8'h10, a2);
        i2c_stop();
        wait_clks(10);
        check("t1_reg_ack", 32'(a1), 32'(0));
        check("t1_data_ack", 32'(a2), 32'(0));
        check("t1_we_count", 32'(we_addr_q.size() - we0), 32'(1));
        check("t1_we_addr", 32'(we_addr_q[we0]), 32'h41);
        check("t1_we_data", 32'(we_data_q[we0]), 32'h10);
        check("t1_ptr_after", 32'(reg_addr), 32'h42);
        check("t1_addressed_lo", 32'(addressed), 32'(0));

        // Burst write with pointer wrap 0xFF -> 0x00
        we0 = we_addr_q.size();
        i2c_start();
        write_byte(8'h72, a0);
        write_byte(8'hFE, a1);
        write_byte(8'hAA, a2);
        write_byte(8'hBB, a3);
        write_byte(8'hCC, a4);
        i2c_stop();
        wait_clks(10);
        check("t2_acks", 32'({a0, a1, a2, a3, a4}), 32'(0));
        check("t2_we_count", 32'(we_addr_q.size() - we0), 32'(3));
        check("t2_we_addr0", 32'(we_addr_q[we0]),     32'hFE);
        check("t2_we_addr1", 32'(we_addr_q[we0 + 1]), 32'hFF);
        check("t2_we_addr2", 32'(we_addr_q[we0 + 2]), 32'h00);
        check("t2_we_data0", 32'(we_data_q[we0]),     32'hAA);
        check("t2_we_data1", 32'(we_data_q[we0 + 1]), 32'hBB);
        check("t2_we_data2", 32'(we_data_q[we0 + 2]), 32'hCC);
        check("t2_ptr_after", 32'(reg_addr), 32'h01);

        // Foreign address 0x3A/W
        we0 = we_addr_q.size(); re0 = re_addr_q.size();
        low0 = low_cnt; adr0 = adr_cnt;
        i2c_start();
        write_byte(8'h74, a0);
        write_byte(8'h55, a1);
        i2c_stop();
        wait_clks(10);
        check("t3_addr_nak", 32'(a0), 32'(1));
        check("t3_data_nak", 32'(a1), 32'(1));
        check("t3_sda_never_low", 32'(low_cnt - low0), 32'(0));
        check("t3_no_we", 32'(we_addr_q.size() - we0), 32'(0));
        check("t3_no_re", 32'(re_addr_q.size() - re0), 32'(0));
        check("t3_not_addressed", 32'(adr_cnt - adr0), 32'(0));

        // Pointer read: W reg 0x10, Sr, 0x39/R, ACK then NAK
        re0 = re_addr_q.size(); nak0 = nak_cnt;
        i2c_start();
        write_byte(8'h72, a0);
        write_byte(8'h10, a1);
        i2c_start();
        write_byte(8'h73, a2);
        read_byte(rb0, 1'b0);
        read_byte(rb1, 1'b1);
        i2c_stop();
        wait_clks(10);
        check("t4_acks", 32'({a0, a1, a2}), 32'(0));
        check("t4_byte0", 32'(rb0), 32'h5A);
        check("t4_byte1", 32'(rb1), 32'hC3);
        check("t4_re_count", 32'(re_addr_q.size() - re0), 32'(2));
        check("t4_re_addr0", 32'(re_addr_q[re0]),     32'h10);
        check("t4_re_addr1", 32'(re_addr_q[re0 + 1]), 32'h11);
        check("t4_nak_pulses", 32'(nak_cnt - nak0), 32'(1));
        check("t4_ptr_after", 32'(reg_addr), 32'h11);

        // 2-clk SCL glitch during data byte is filtered out
        we0 = we_addr_q.size();
        i2c_start();
        write_byte(8'h72, a0);
        write_byte(8'h41, a1);
        write_byte(8'h10, a2, 2);
        i2c_stop();
        wait_clks(10);
        check("t5_acks", 32'({a0, a1, a2}), 32'(0));
        check("t5_we_count", 32'(we_addr_q.size() - we0), 32'(1));
        check("t5_we_data", 32'(we_data_q[we0]), 32'h10);
        check("t5_ptr_after", 32'(reg_addr), 32'h42);

        // STOP in the middle of a data byte
        we0 = we_addr_q.size();
        i2c_start();
        write_byte(8'h72, a0);
        write_byte(8'h41, a1);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_stop();
        wait_clks(10);
        check("t5b_no_we", 32'(we_addr_q.size() - we0), 32'(0));
        check("t5b_addressed_lo", 32'(addressed), 32'(0));
        check("t5b_ptr", 32'(reg_addr), 32'h41);

        // Reset asserted while the address ACK is being driven
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(i == 1 || (i >= 4 && i <= 6));
        m_sda = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            wait_clks(1);
            if (sda_oen === 1'b0) seen = 1'b1;
        end
        check("t6_ack_driven", 32'(seen), 32'(1));
        #3 rst_n = 1'b0;
        #1;
        check("t6_oen_async", 32'(sda_oen), 32'(1));
        check("t6_addressed_rst", 32'(addressed), 32'(0));
        check("t6_ptr_rst", 32'(reg_addr), 32'h00);
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(10);
        i2c_stop();
        wait_clks(10);
        we0 = we_addr_q.size();
        i2c_start();
        write_byte(8'h72, a0);
        write_byte(8'h20, a1);
        write_byte(8'h77, a2);
        i2c_stop();
        wait_clks(10);
        check("t6_acks", 32'({a0, a1, a2}), 32'(0));
        check("t6_we_count", 32'(we_addr_q.size() - we0), 32'(1));
        check("t6_we_addr", 32'(we_addr_q[we0]), 32'h20);
        check("t6_we_data", 32'(we_data_q[we0]), 32'h77);
        check("t6_ptr_after", 32'(reg_addr), 32'h21);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
